// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the asynchronous-FIFO write-port arbiter.
package fifo_write_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int unsigned REQ_COUNT = 2;

   // Pointers, lengths and the free count carry one wrap bit above the address.
   function automatic int unsigned ptr_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arb2.sv
// Two-way round-robin pick: passes a lone eligible bit, breaks ties with rr.
module rr_arb2
   import fifo_write_arbiter_pkg::*;
(
   input  logic [REQ_COUNT-1:0] elig,
   input  logic                 rr,
   output logic [REQ_COUNT-1:0] grant_c
);

   always_comb begin
      grant_c = elig;
      if (&elig) grant_c = rr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Grants the FIFO write port to one of two requesters for a whole burst,
// only when the FIFO has room for the full burst.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
)
(
   input  logic                                w_clk,
   input  logic                                w_rst_n,
   input  logic [ptr_width(ADDR_WIDTH)-1:0]    write_addr,
   input  logic [ptr_width(ADDR_WIDTH)-1:0]    read_addr,
   input  logic                                req0,
   input  logic                                req1,
   input  logic [ptr_width(ADDR_WIDTH)-1:0]    len0,
   input  logic [ptr_width(ADDR_WIDTH)-1:0]    len1,
   input  logic                                valid0,
   input  logic                                valid1,
   input  logic [DATA_WIDTH-1:0]               data0,
   input  logic [DATA_WIDTH-1:0]               data1,
   output logic                                gnt0,
   output logic                                gnt1,
   output logic                                w_en,
   output logic [DATA_WIDTH-1:0]               w_data,
   output logic                                busy,
   output logic                                err
);

   localparam int unsigned PW   = ptr_width(ADDR_WIDTH);
   localparam int unsigned SIZE = 2 ** ADDR_WIDTH;

   state_t               state;
   logic [PW-1:0]        used;
   logic [PW-1:0]        free;
   logic [PW-1:0]        beats_left;
   logic                 rr;
   logic [REQ_COUNT-1:0] req;
   logic [REQ_COUNT-1:0] elig;
   logic [REQ_COUNT-1:0] illegal;
   logic [REQ_COUNT-1:0] grant;
   logic [REQ_COUNT-1:0] seen;
   logic [REQ_COUNT-1:0] seen_next;

   // Modular pointer difference handles the wrap bit; equal pointers give SIZE free.
   assign used = write_addr - read_addr;
   assign free = PW'(SIZE) - used;
   assign req  = {req1, req0};

   always_comb begin
      illegal[0] = req0 && ((len0 == '0) || (len0 > PW'(SIZE)));
      illegal[1] = req1 && ((len1 == '0) || (len1 > PW'(SIZE)));
      elig[0]    = req0 && (len0 != '0) && (len0 <= free);
      elig[1]    = req1 && (len1 != '0) && (len1 <= free);
      // An illegal request is reported once; dropping req re-arms the report.
      seen_next  = (seen | ((state == IDLE) ? illegal : '0)) & req;
   end

   rr_arb2 u_rr_arb2 (
      .elig    (elig),
      .rr      (rr),
      .grant_c (grant)
   );

   // Write port follows the granted requester with no added latency.
   assign w_en = (gnt0 && valid0) || (gnt1 && valid1);

   always_comb begin
      w_data = '0;
      if (gnt0)      w_data = data0;
      else if (gnt1) w_data = data1;
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         state      <= IDLE;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         beats_left <= '0;
         rr         <= 1'b0;
         seen       <= '0;
      end else begin
         seen <= seen_next;
         err  <= (state == IDLE) && (|(illegal & ~seen));
         if (state == IDLE) begin
            if (grant[0]) begin
               gnt0       <= 1'b1;
               busy       <= 1'b1;
               beats_left <= len0;
               state      <= BURST;
            end else if (grant[1]) begin
               gnt1       <= 1'b1;
               busy       <= 1'b1;
               beats_left <= len1;
               state      <= BURST;
            end
         end else if (w_en) begin
            beats_left <= beats_left - PW'(1);
            // Last beat: release and hand priority to the other requester.
            if (beats_left == PW'(1)) begin
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b0;
               rr    <= gnt0;
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random checks of fifo_write_arbiter against a transaction-level model.
module tb_fifo_write_arbiter;

   localparam int unsigned AW   = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned PW   = AW + 1;
   localparam int          SIZE = 16;

   logic          w_clk;
   logic          w_rst_n;
   logic [PW-1:0] write_addr, read_addr;
   logic          req0, req1;
   logic [PW-1:0] len0, len1;
   logic          valid0, valid1;
   logic [DW-1:0] data0, data1;
   logic          gnt0, gnt1, w_en, busy, err;
   logic [DW-1:0] w_data;

   int checks = 0;
   int errors = 0;

   // Model: who owns the port (-1 none), beats still owed, tie-break favourite.
   int m_owner, m_rem, m_rr;
   bit m_err;
   bit m_seen [2];

   fifo_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .w_clk      (w_clk),
      .w_rst_n    (w_rst_n),
      .write_addr (write_addr),
      .read_addr  (read_addr),
      .req0       (req0),
      .req1       (req1),
      .len0       (len0),
      .len1       (len1),
      .valid0     (valid0),
      .valid1     (valid1),
      .data0      (data0),
      .data1      (data1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .w_en       (w_en),
      .w_data     (w_data),
      .busy       (busy),
      .err        (err)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_comb(input string tag);
      logic          exp_en;
      logic [DW-1:0] exp_d;
      exp_en = (m_owner == 0 && valid0) || (m_owner == 1 && valid1);
      exp_d  = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : '0;
      chk({tag, ".w_en"}, 32'(w_en), 32'(exp_en));
      chk({tag, ".w_data"}, 32'(w_data), 32'(exp_d));
   endtask

   task automatic check_reg(input string tag);
      chk({tag, ".gnt0"}, 32'(gnt0), 32'(m_owner == 0));
      chk({tag, ".gnt1"}, 32'(gnt1), 32'(m_owner == 1));
      chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
      chk({tag, ".err"},  32'(err),  32'(m_err));
   endtask

   // One clock: check combinational outputs, predict, clock, check registered outputs.
   task automatic cycle(input string tag);
      int rq [2];
      int ln [2];
      int vl [2];
      int fr, pick, own_n, rem_n, rr_n;
      bit err_n;
      bit el [2];
      bit seen_n [2];
      #1;
      check_comb(tag);
      rq[0] = int'(req0);   rq[1] = int'(req1);
      ln[0] = int'(len0);   ln[1] = int'(len1);
      vl[0] = int'(valid0); vl[1] = int'(valid1);
      fr    = SIZE - ((int'(write_addr) - int'(read_addr) + 32) % 32);
      own_n = m_owner; rem_n = m_rem; rr_n = m_rr; err_n = 1'b0;
      for (int i = 0; i < 2; i++) seen_n[i] = m_seen[i];
      if (!w_rst_n) begin
         own_n = -1; rem_n = 0; rr_n = 0;
         for (int i = 0; i < 2; i++) seen_n[i] = 1'b0;
      end else begin
         if (m_owner < 0) begin
            for (int i = 0; i < 2; i++) begin
               if (rq[i] != 0 && (ln[i] < 1 || ln[i] > SIZE)) begin
                  if (!m_seen[i]) err_n = 1'b1;
                  seen_n[i] = 1'b1;
               end
               el[i] = (rq[i] != 0) && ln[i] >= 1 && ln[i] <= fr;
            end
            pick = -1;
            if (el[0] && el[1]) pick = m_rr;
            else if (el[0])     pick = 0;
            else if (el[1])     pick = 1;
            if (pick >= 0) begin
               own_n = pick;
               rem_n = ln[pick];
            end
         end else if (vl[m_owner] != 0) begin
            rem_n = m_rem - 1;
            if (rem_n == 0) begin
               rr_n  = 1 - m_owner;
               own_n = -1;
            end
         end
         for (int i = 0; i < 2; i++) if (rq[i] == 0) seen_n[i] = 1'b0;
      end
      @(posedge w_clk);
      #1;
      m_owner = own_n; m_rem = rem_n; m_rr = rr_n; m_err = err_n;
      for (int i = 0; i < 2; i++) m_seen[i] = seen_n[i];
      check_reg(tag);
   endtask

   // Cycle, then release the request that was just granted.
   task automatic step(input string tag);
      cycle(tag);
      if (m_owner == 0) req0 = 1'b0;
      if (m_owner == 1) req1 = 1'b0;
   endtask

   function automatic logic [PW-1:0] pick_len();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return '0;
      if (r == 1) return PW'($urandom_range(17, 31));
      return PW'($urandom_range(1, SIZE));
   endfunction

   initial begin
      bit pat [4];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      w_rst_n = 1'b0; write_addr = '0; read_addr = '0;
      req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
      valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
      m_owner = -1; m_rem = 0; m_rr = 0; m_err = 1'b0;
      m_seen[0] = 1'b0; m_seen[1] = 1'b0;
      repeat (2) @(posedge w_clk);
      #1;
      step("reset");
      chk("reset_busy", 32'(busy), 32'd0);

      // Reset in the middle of a burst.
      w_rst_n = 1'b1; req0 = 1'b1; len0 = PW'(5); valid0 = 1'b1; data0 = 8'h5a;
      repeat (3) step("mid_burst");
      w_rst_n = 1'b0;
      step("mid_reset");
      chk("mid_reset_gnt0", 32'(gnt0), 32'd0);
      chk("mid_reset_w_en", 32'(w_en), 32'd0);
      w_rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; len0 = PW'(2); len1 = PW'(2);
      valid1 = 1'b1; data1 = 8'ha5;
      step("post_reset");
      chk("post_reset_gnt0", 32'(gnt0), 32'd1);
      repeat (7) step("post_reset_drain");

      // Contention with an empty FIFO.
      req0 = 1'b1; req1 = 1'b1; len0 = PW'(4); len1 = PW'(3);
      for (int k = 1; k <= 9; k++) begin
         data0 = DW'($urandom); data1 = DW'($urandom);
         step("contend");
         if (k == 5) chk("contend_idle_gap", 32'(busy), 32'd0);
         if (k == 6) chk("contend_gnt1", 32'(gnt1), 32'd1);
         if (k == 9) chk("contend_done", 32'(gnt1), 32'd0);
      end
      req0 = 1'b1; req1 = 1'b1; len0 = PW'(1); len1 = PW'(1);
      step("contend_again");
      chk("contend_again_gnt0", 32'(gnt0), 32'd1);
      repeat (4) step("contend_again_drain");

      // Space check: free = 4, then 6.
      write_addr = PW'(12); read_addr = '0;
      req0 = 1'b1; req1 = 1'b1; len0 = PW'(6); len1 = PW'(4);
      step("space");
      chk("space_gnt1", 32'(gnt1), 32'd1);
      repeat (5) step("space_burst");
      chk("space_wait_gnt0", 32'(gnt0), 32'd0);
      read_addr = PW'(2);
      step("space_open");
      chk("space_open_gnt0", 32'(gnt0), 32'd1);
      repeat (7) step("space_drain");

      // Wrapped pointers: free = 2, then 3.
      write_addr = PW'(2); read_addr = PW'(20);
      req0 = 1'b1; req1 = 1'b1; len0 = PW'(3); len1 = PW'(2);
      step("wrap");
      chk("wrap_gnt1", 32'(gnt1), 32'd1);
      repeat (3) step("wrap_burst");
      chk("wrap_held_gnt0", 32'(gnt0), 32'd0);
      read_addr = PW'(21);
      step("wrap_open");
      chk("wrap_open_gnt0", 32'(gnt0), 32'd1);
      repeat (4) step("wrap_drain");

      // Valid gaps during a burst.
      write_addr = '0; read_addr = '0; valid0 = 1'b0; valid1 = 1'b1;
      req0 = 1'b1; len0 = PW'(3);
      step("gap_grant");
      for (int k = 0; k < 4; k++) begin
         valid0 = pat[k]; data0 = DW'($urandom);
         #1;
         chk("gap_w_en", 32'(w_en), 32'(pat[k]));
         chk("gap_w_data", 32'(w_data), 32'(data0));
         step("gap");
      end
      chk("gap_release", 32'(gnt0), 32'd0);

      // Illegal lengths on requester 1 while requester 0 runs normally.
      valid0 = 1'b1; valid1 = 1'b1;
      req0 = 1'b1; len0 = PW'(2); req1 = 1'b1; len1 = '0;
      step("illegal_a");
      chk("illegal_a_err", 32'(err), 32'd1);
      chk("illegal_a_gnt0", 32'(gnt0), 32'd1);
      step("illegal_a2");
      req1 = 1'b0;
      step("illegal_drop");
      req1 = 1'b1; len1 = PW'(17);
      step("illegal_b");
      chk("illegal_b_err", 32'(err), 32'd1);
      chk("illegal_b_gnt1", 32'(gnt1), 32'd0);
      step("illegal_b2");
      chk("illegal_b2_err", 32'(err), 32'd0);
      req1 = 1'b0;
      step("illegal_end");

      // Random traffic with protocol-respecting requesters.
      for (int n = 0; n < 800; n++) begin
         read_addr  = PW'($urandom_range(0, 31));
         write_addr = read_addr + PW'($urandom_range(0, SIZE));
         valid0 = ($urandom_range(0, 3) != 0);
         valid1 = ($urandom_range(0, 3) != 0);
         data0  = DW'($urandom);
         data1  = DW'($urandom);
         if (!req0 && m_owner != 0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; len0 = pick_len();
         end else if (req0 && (len0 == '0 || len0 > PW'(SIZE)) && $urandom_range(0, 2) == 0) begin
            req0 = 1'b0;
         end
         if (!req1 && m_owner != 1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; len1 = pick_len();
         end else if (req1 && (len1 == '0 || len1 > PW'(SIZE)) && $urandom_range(0, 2) == 0) begin
            req1 = 1'b0;
         end
         if ($urandom_range(0, 299) == 0) w_rst_n = 1'b0;
         else                             w_rst_n = 1'b1;
         step("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the single write port of the asynchronous FIFO between two write-side requesters, in the write clock domain. A requester is granted the port for a whole burst only when the FIFO has enough free locations to take that burst. The free count comes from the write pointer and the read pointer, which has already been synchronized into the write domain. Grants alternate round-robin under contention, and the arbiter drives the FIFO write enable and data directly.

## Interface
Parameters:
- ADDR_WIDTH, 4, FIFO address width; SIZE = 2**ADDR_WIDTH locations.
- DATA_WIDTH, 8, data width.

Ports (clock and reset first):
- w_clk  in  1  write-domain clock.
- w_rst_n  in  1  reset; synchronous, active-low.
- write_addr  in  ADDR_WIDTH+1  binary write pointer (MSB = wrap bit).
- read_addr  in  ADDR_WIDTH+1  binary read pointer, already synchronized into w_clk.
- req0, req1  in  1  burst request, held until the corresponding grant.
- len0, len1  in  ADDR_WIDTH+1  burst length in beats, stable while req is high.
- valid0, valid1  in  1  beat valid from the requester during its grant.
- data0, data1  in  DATA_WIDTH  beat data.
- gnt0, gnt1  out  1  registered grant; high for the whole burst.
- w_en  out  1  FIFO write enable.
- w_data  out  DATA_WIDTH  FIFO write data.
- busy  out  1  registered; high while in BURST.
- err  out  1  registered one-cycle pulse on an illegal request.

## Operation
- Free count: `free = SIZE - ((write_addr - read_addr) mod 2**(ADDR_WIDTH+1))`.
  - Computed in ADDR_WIDTH+1 bits, so wrap-bit differences are handled.
  - free = SIZE when the pointers are equal; free = 0 when full.
- A request i is eligible when `1 <= len_i <= free`.
- FSM states: IDLE, BURST.
- IDLE:
  - Evaluate eligibility of req0 and req1 each cycle.
  - If one is eligible, grant it.
  - If both are eligible, grant the one indicated by the round-robin pointer `rr`; `rr` = 0 favours requester 0.
  - On a grant: set gnt_i, load `beats_left = len_i`, go to BURST.
  - The space is reserved at grant. Reads only increase free, so no recheck is needed during the burst.
  - A request that is legal but not yet eligible waits with no error.
- BURST:
  - Combinationally, `w_en = valid_i` and `w_data = data_i` for the granted requester i; w_data = 0 when no grant is active.
  - Each cycle with valid_i high decrements beats_left.
  - On the beat that makes beats_left zero: clear the grant, set `rr` to the other requester, return to IDLE.
  - req_i is ignored during BURST; dropping req does not abort the burst.
  - valid from the non-granted requester is ignored.
- Illegal request: req_i high in IDLE with `len_i == 0` or `len_i > SIZE`.
  - Never granted.
  - err pulses once on the first such cycle and again only after req_i drops and re-rises.
  - An illegal request does not block the other requester.
- Reset (any cycle, including mid-burst):
  - State = IDLE; gnt0 = gnt1 = 0; busy = 0; err = 0; beats_left = 0; rr = 0.
  - Hence w_en = 0.
  - A partially written burst is the requester's responsibility.

## Timing
- Request to grant: req sampled at edge k in IDLE → gnt high from edge k+1.
- First beat can be written in the first gnt cycle; each valid cycle writes one beat; no added latency on w_en.
- After the last beat, exactly one IDLE cycle precedes the next grant, so free reflects the updated write pointer.
- A burst of N beats with continuous valid occupies N+1 cycles per grant.
- busy equals gnt0 | gnt1.

## Structure
- Shared package/include holds:
  - state encoding (IDLE = 1'b0, BURST = 1'b1);
  - a REQ_COUNT = 2 constant;
  - the free-count width rule (ADDR_WIDTH+1).
- One sub-module, rr_arb2: two eligibility bits plus the rr pointer in, one-hot grant out; purely combinational.
- The free count is computed inline.

## Test plan
ADDR_WIDTH = 4, so SIZE = 16.
- Reset mid-burst: gnt0 active with beats_left = 3, then w_rst_n = 0 for one edge → gnt0 = gnt1 = busy = err = w_en = 0. req0 and req1 then both eligible → gnt0 first (rr = 0).
- Contention, pointers equal (free = 16), req0 len 4, req1 len 3, valid always 1 → gnt0 for 4 cycles with 4 w_en pulses, 1 IDLE cycle, gnt1 for 3 cycles. A new simultaneous request then grants requester 0 again.
- Space check, write_addr = 12, read_addr = 0 (free = 4), req0 len 6, req1 len 4 → gnt1 granted, req0 waits. After read_addr moves to 2 (free = 6) → gnt0.
- Wrap arithmetic, write_addr = 5'd2, read_addr = 5'd20 (free = 2) → len 2 granted, len 3 held off.
- Valid gaps: gnt0 with len 3, valid0 pattern 1,0,1,1 → w_en 1,0,1,1; gnt0 drops after the 4th cycle; w_data follows data0.
- Illegal length: req1 with len 0, then len 17 → one err pulse each (req toggled in between), never granted. req0 with len 2 granted normally meanwhile.
